// File: rtl/dmem_port_arbiter.sv
// ============================================================================
// dmem_port_arbiter : round-robin sharing of one data-memory port, one access
// in flight, fixed read latency. Optional grant counters: DMEM_ARB_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_port_arbiter #(
  parameter int WIDTH       = 32,
  parameter int NREQ        = 2,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_we,
  input  logic [NREQ*WIDTH-1:0] req_addr,
  input  logic [NREQ*WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      rdata,
  output logic                  busy,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [WIDTH-1:0]      mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic [NREQ*16-1:0]    stat_grants
`endif
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNTW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_ISSUE = 2'd1;
  localparam logic [1:0] c_ST_WAIT  = 2'd2;
  localparam logic [1:0] c_ST_RESP  = 2'd3;

  localparam logic [IDXW:0]   c_NREQ     = (IDXW+1)'(NREQ);
  localparam logic [IDXW-1:0] c_LAST     = IDXW'(NREQ-1);
  localparam logic [CNTW-1:0] c_LAT_LOAD = CNTW'(MEM_LATENCY-1);

  logic [1:0]       r_state;
  logic [IDXW-1:0]  r_rr_ptr;
  logic [IDXW-1:0]  r_idx;
  logic             r_we;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [CNTW-1:0]  r_cnt;

  logic [IDXW:0]    w_cand;
  logic [IDXW-1:0]  w_pick;
  logic             w_found;

  // First asserted request at or after the round-robin pointer, wrapping mod NREQ.
  always_comb begin
    w_cand  = '0;
    w_pick  = r_rr_ptr;
    w_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (IDXW+1)'(k);
      if (w_cand >= c_NREQ) begin
        w_cand = w_cand - c_NREQ;
      end
      if (!w_found && req[w_cand[IDXW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_cand[IDXW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= c_ST_IDLE;
      r_rr_ptr <= '0;
      r_idx    <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_found) begin
            r_idx   <= w_pick;
            r_we    <= req_we[w_pick];
            r_addr  <= req_addr[w_pick*WIDTH +: WIDTH];
            r_wdata <= req_wdata[w_pick*WIDTH +: WIDTH];
            r_state <= c_ST_ISSUE;
          end
        end
        c_ST_ISSUE: begin
          r_rr_ptr <= (r_idx == c_LAST) ? '0 : r_idx + IDXW'(1);
          r_cnt    <= c_LAT_LOAD;
          r_state  <= (MEM_LATENCY == 1) ? c_ST_RESP : c_ST_WAIT;
        end
        c_ST_WAIT: begin
          r_cnt <= r_cnt - CNTW'(1);
          if (r_cnt <= CNTW'(1)) begin
            r_state <= c_ST_RESP;
          end
        end
        c_ST_RESP: begin
          r_state <= c_ST_IDLE;
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  // All outputs decode from registered state, so none reach back to req.
  always_comb begin
    grant     = '0;
    done      = '0;
    rdata     = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = (r_state != c_ST_IDLE);
    if (r_state != c_ST_IDLE) begin
      grant[r_idx] = 1'b1;
      mem_addr     = r_addr;
      mem_wdata    = r_wdata;
    end
    if (r_state == c_ST_ISSUE) begin
      mem_en = 1'b1;
      mem_we = r_we;
    end
    if (r_state == c_ST_RESP) begin
      done[r_idx] = 1'b1;
      if (!r_we) begin
        rdata = mem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  for (genvar g = 0; g < NREQ; g++) begin : g_stats
    logic [15:0] r_grants;
    always_ff @(posedge clk) begin
      if (reset || stat_clr) begin
        r_grants <= '0;
      end else if (r_state == c_ST_ISSUE && r_idx == IDXW'(g) && r_grants != 16'hFFFF) begin
        r_grants <= r_grants + 16'd1;
      end
    end
    assign stat_grants[g*16 +: 16] = r_grants;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// ============================================================================
// tb_dmem_port_arbiter : randomized requesters and memory against a
// transaction-level reference model; latency 1 and latency 3 instances.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dmem_port_arbiter;

  localparam int W     = 32;
  localparam int N     = 3;
  localparam int NCYC  = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset = 1'b1;
  logic [1:0][N-1:0]     req, req_we, grant, done;
  logic [1:0][N*W-1:0]   req_addr, req_wdata;
  logic [1:0][W-1:0]     rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]            busy, mem_en, mem_we;
`ifdef DMEM_ARB_STATS_EN
  logic [1:0]            stat_clr;
  logic [1:0][N*16-1:0]  stat_grants;
`endif

  dmem_port_arbiter #(.WIDTH(W), .NREQ(N), .MEM_LATENCY(1)) u_dut0 (
    .clk(clk), .reset(reset), .req(req[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .grant(grant[0]),
    .done(done[0]), .rdata(rdata[0]), .busy(busy[0]), .mem_en(mem_en[0]),
    .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0])
`ifdef DMEM_ARB_STATS_EN
    , .stat_clr(stat_clr[0]), .stat_grants(stat_grants[0])
`endif
  );

  dmem_port_arbiter #(.WIDTH(W), .NREQ(N), .MEM_LATENCY(3)) u_dut1 (
    .clk(clk), .reset(reset), .req(req[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .grant(grant[1]),
    .done(done[1]), .rdata(rdata[1]), .busy(busy[1]), .mem_en(mem_en[1]),
    .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1])
`ifdef DMEM_ARB_STATS_EN
    , .stat_clr(stat_clr[1]), .stat_grants(stat_grants[1])
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: one transaction record per instance, timed by cycle numbers.
  int          lat [2] = '{1, 3};
  bit          m_act [2];
  int          m_idx [2];
  bit          m_we [2];
  logic [W-1:0] m_addr [2], m_wdata [2], m_rd [2];
  int          m_issue [2];
  int          m_ptr [2];
  logic [W-1:0] ref_mem [2][16];
`ifdef DMEM_ARB_STATS_EN
  int          m_stat [2][N];
`endif

  // Environment: memory contents, pending read return, requester states
  // (0 idle, 1 requesting, 2 dropped early awaiting done, 3 cool-down after done).
  logic [W-1:0] env_mem [2][16];
  bit          rd_pend [2];
  int          rd_cyc [2];
  logic [W-1:0] rd_val [2];
  int          rs [2][N];

  initial begin
    for (int u = 0; u < 2; u++) begin
      m_act[u] = 1'b0; m_ptr[u] = 0; rd_pend[u] = 1'b0;
      for (int a = 0; a < 16; a++) begin
        env_mem[u][a] = $urandom;
        ref_mem[u][a] = env_mem[u][a];
      end
      for (int i = 0; i < N; i++) begin
        rs[u][i] = 0;
`ifdef DMEM_ARB_STATS_EN
        m_stat[u][i] = 0;
`endif
      end
    end
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0; mem_rdata = '0;
`ifdef DMEM_ARB_STATS_EN
    stat_clr = '0;
`endif

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      reset = (c < 3) || ($urandom_range(0, 299) == 0);
      for (int u = 0; u < 2; u++) begin
        mem_rdata[u] = (rd_pend[u] && rd_cyc[u] == c) ? rd_val[u] : W'($urandom);
`ifdef DMEM_ARB_STATS_EN
        stat_clr[u] = ($urandom_range(0, 63) == 0);
`endif
        for (int i = 0; i < N; i++) begin
          case (rs[u][i])
            0: begin
              if ($urandom_range(0, 3) == 0) begin
                rs[u][i] = 1;
                req[u][i] = 1'b1;
                req_we[u][i] = 1'($urandom_range(0, 1));
                req_addr[u][i*W +: W] = W'($urandom);
                req_wdata[u][i*W +: W] = W'($urandom);
              end
            end
            1: begin
              if (grant[u][i]) begin
                if ($urandom_range(0, 15) == 0) begin
                  rs[u][i] = 2;
                  req[u][i] = 1'b0;
                end
                req_we[u][i] = 1'($urandom_range(0, 1));
                req_addr[u][i*W +: W] = W'($urandom);
                req_wdata[u][i*W +: W] = W'($urandom);
              end
            end
            3: begin
              rs[u][i] = 0;
              req[u][i] = 1'b0;
            end
            default: req[u][i] = 1'b0;
          endcase
        end
      end
      #1;

      for (int u = 0; u < 2; u++) begin
        logic [N-1:0] e_grant, e_done;
        bit           win, e_en;
        string        tg;
        win     = m_act[u] && c >= m_issue[u] && c <= m_issue[u] + lat[u];
        e_en    = win && c == m_issue[u];
        e_grant = '0;
        e_done  = '0;
        if (win) e_grant[m_idx[u]] = 1'b1;
        if (win && c == m_issue[u] + lat[u]) e_done[m_idx[u]] = 1'b1;
        tg = $sformatf("u%0d c%0d", u, c);
        check_eq({tg, " grant"}, 128'(grant[u]), 128'(e_grant));
        check_eq({tg, " done"}, 128'(done[u]), 128'(e_done));
        check_eq({tg, " busy"}, 128'(busy[u]), 128'(win));
        check_eq({tg, " mem_en"}, 128'(mem_en[u]), 128'(e_en));
        check_eq({tg, " mem_we"}, 128'(mem_we[u]), 128'(e_en && m_we[u]));
        check_eq({tg, " mem_addr"}, 128'(mem_addr[u]), win ? 128'(m_addr[u]) : 128'(0));
        check_eq({tg, " mem_wdata"}, 128'(mem_wdata[u]), win ? 128'(m_wdata[u]) : 128'(0));
        if (e_done != '0)
          check_eq({tg, " rdata"}, 128'(rdata[u]), m_we[u] ? 128'(0) : 128'(m_rd[u]));
`ifdef DMEM_ARB_STATS_EN
        for (int i = 0; i < N; i++)
          check_eq({tg, $sformatf(" stat%0d", i)}, 128'(stat_grants[u][i*16 +: 16]), 128'(m_stat[u][i]));
`endif

        // Environment reacts to what the DUT drives.
        if (mem_en[u]) begin
          if (mem_we[u]) begin
            env_mem[u][mem_addr[u][3:0]] = mem_wdata[u];
          end else begin
            rd_pend[u] = 1'b1;
            rd_cyc[u]  = c + lat[u];
            rd_val[u]  = env_mem[u][mem_addr[u][3:0]];
          end
        end
        for (int i = 0; i < N; i++)
          if (done[u][i] && (rs[u][i] == 1 || rs[u][i] == 2)) rs[u][i] = 3;

        // Advance the model to the next cycle.
        if (reset) begin
          m_act[u] = 1'b0;
          m_ptr[u] = 0;
          rd_pend[u] = 1'b0;
          for (int i = 0; i < N; i++) begin
            rs[u][i] = 3;
`ifdef DMEM_ARB_STATS_EN
            m_stat[u][i] = 0;
`endif
          end
        end else begin
`ifdef DMEM_ARB_STATS_EN
          for (int i = 0; i < N; i++) begin
            if (stat_clr[u]) m_stat[u][i] = 0;
            else if (e_en && m_idx[u] == i && m_stat[u][i] < 65535) m_stat[u][i]++;
          end
`endif
          if (m_act[u]) begin
            if (c == m_issue[u] + lat[u]) m_act[u] = 1'b0;
          end else if (req[u] != '0) begin
            int j;
            j = -1;
            for (int k = 0; k < N; k++)
              if (j < 0 && req[u][(m_ptr[u] + k) % N]) j = (m_ptr[u] + k) % N;
            m_act[u]   = 1'b1;
            m_idx[u]   = j;
            m_we[u]    = req_we[u][j];
            m_addr[u]  = req_addr[u][j*W +: W];
            m_wdata[u] = req_wdata[u][j*W +: W];
            m_issue[u] = c + 1;
            m_ptr[u]   = (j + 1) % N;
            if (m_we[u]) begin
              ref_mem[u][m_addr[u][3:0]] = m_wdata[u];
              m_rd[u] = '0;
            end else begin
              m_rd[u] = ref_mem[u][m_addr[u][3:0]];
            end
          end
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
